// File: rtl/video_timing_gen.sv
// Two-axis video timing generator with runtime mode programming applied at frame boundaries,
// plus frame counter and sticky line-match interrupt.
module video_timing_gen #(
  parameter int CW      = 12,
  parameter int H_RES   = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_RES   = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33,
  parameter bit H_POL   = 1'b0,
  parameter bit V_POL   = 1'b0,
  parameter int FRAME_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pix_en,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic                 cfg_sel,
  input  logic [CW-2:0]        cfg_res,
  input  logic [CW-2:0]        cfg_fp,
  input  logic [CW-2:0]        cfg_sync,
  input  logic [CW-2:0]        cfg_bp,
  input  logic                 cfg_pol,
  input  logic signed [CW-1:0] irq_line,
  input  logic                 irq_clear,
  output logic signed [CW-1:0] x,
  output logic signed [CW-1:0] y,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 de,
  output logic                 frame_start,
  output logic                 irq,
  output logic [FRAME_W-1:0]   frame_cnt
);

  typedef logic [CW-2:0] fld_t;

  localparam logic signed [CW-1:0] ONE = CW'(1);
  localparam logic signed [CW-1:0] HB0 = CW'(H_FP + H_SYNC + H_BP);
  localparam logic signed [CW-1:0] VB0 = CW'(V_FP + V_SYNC + V_BP);

  // Index 0 = horizontal axis, index 1 = vertical axis.
  logic [1:0][CW-2:0] act_res, act_fp, act_sync, act_bp;
  logic [1:0][CW-2:0] stg_res, stg_fp, stg_sync, stg_bp;
  logic [1:0]         act_pol, stg_pol, pending;

  logic signed [CW-1:0] hc, vc;
  logic signed [CW-1:0] bh, bv, bh_nx, bv_nx, hlast, vlast;
  logic                 line_end, frame_end, cfg_accept, irq_set;

  function automatic logic signed [CW-1:0] blank(input fld_t fp, input fld_t sync, input fld_t bp);
    return $signed({1'b0, fp}) + $signed({1'b0, sync}) + $signed({1'b0, bp});
  endfunction

  // Sync window is -(sync+bp) <= count < -bp; empty when sync is zero.
  function automatic logic sync_out(input logic signed [CW-1:0] count, input fld_t sync,
                                    input fld_t bp, input logic pol);
    logic signed [CW-1:0] lo, hi;
    logic                 cond;
    lo   = -($signed({1'b0, sync}) + $signed({1'b0, bp}));
    hi   = -$signed({1'b0, bp});
    cond = (count >= lo) && (count < hi);
    return pol ? cond : ~cond;
  endfunction

  assign bh    = blank(act_fp[0], act_sync[0], act_bp[0]);
  assign bv    = blank(act_fp[1], act_sync[1], act_bp[1]);
  assign bh_nx = pending[0] ? blank(stg_fp[0], stg_sync[0], stg_bp[0]) : bh;
  assign bv_nx = pending[1] ? blank(stg_fp[1], stg_sync[1], stg_bp[1]) : bv;
  assign hlast = $signed({1'b0, act_res[0]}) - ONE;
  assign vlast = $signed({1'b0, act_res[1]}) - ONE;

  assign line_end   = pix_en && (hc == hlast);
  assign frame_end  = line_end && (vc == vlast);
  assign cfg_ready  = ~pending[cfg_sel];
  assign cfg_accept = cfg_valid && cfg_ready;
  assign irq_set    = pix_en && (vc == irq_line) && (hc == -bh);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      act_res     <= {fld_t'(V_RES), fld_t'(H_RES)};
      act_fp      <= {fld_t'(V_FP), fld_t'(H_FP)};
      act_sync    <= {fld_t'(V_SYNC), fld_t'(H_SYNC)};
      act_bp      <= {fld_t'(V_BP), fld_t'(H_BP)};
      act_pol     <= {V_POL, H_POL};
      stg_res     <= {fld_t'(V_RES), fld_t'(H_RES)};
      stg_fp      <= {fld_t'(V_FP), fld_t'(H_FP)};
      stg_sync    <= {fld_t'(V_SYNC), fld_t'(H_SYNC)};
      stg_bp      <= {fld_t'(V_BP), fld_t'(H_BP)};
      stg_pol     <= {V_POL, H_POL};
      pending     <= '0;
      hc          <= -HB0;
      vc          <= -VB0;
      x           <= -HB0;
      y           <= -VB0;
      hsync       <= ~H_POL;
      vsync       <= ~V_POL;
      de          <= 1'b0;
      frame_start <= 1'b0;
      irq         <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      if (cfg_accept) begin
        stg_res[cfg_sel]  <= (cfg_res == '0) ? fld_t'(1) : cfg_res;
        stg_fp[cfg_sel]   <= cfg_fp;
        stg_sync[cfg_sel] <= cfg_sync;
        stg_bp[cfg_sel]   <= cfg_bp;
        stg_pol[cfg_sel]  <= cfg_pol;
        pending[cfg_sel]  <= 1'b1;
      end
      // A write landing on the frame-end cycle sees pending still clear, so it waits a frame.
      if (frame_end) begin
        for (int i = 0; i < 2; i++) begin
          if (pending[i]) begin
            act_res[i]  <= stg_res[i];
            act_fp[i]   <= stg_fp[i];
            act_sync[i] <= stg_sync[i];
            act_bp[i]   <= stg_bp[i];
            act_pol[i]  <= stg_pol[i];
            pending[i]  <= 1'b0;
          end
        end
        frame_cnt <= frame_cnt + 1'b1;
      end
      if (pix_en) begin
        if (line_end) begin
          hc <= frame_end ? -bh_nx : -bh;
          vc <= frame_end ? -bv_nx : vc + ONE;
        end else begin
          hc <= hc + ONE;
        end
        // output stage: one enabled pixel behind the counters, all fields aligned
        x           <= hc;
        y           <= vc;
        hsync       <= sync_out(hc, act_sync[0], act_bp[0], act_pol[0]);
        vsync       <= sync_out(vc, act_sync[1], act_bp[1], act_pol[1]);
        de          <= ~hc[CW-1] && ~vc[CW-1];
        frame_start <= (hc == '0) && (vc == '0);
      end
      irq <= irq_set | (irq & ~irq_clear);
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen in a tiny reset mode (H 4/1/1/1, V 2/1/1/1):
// stimulus pushes expected outputs per enabled pixel, a negedge monitor pops and compares.
module tb_video_timing_gen;

  localparam int CW = 12;

  logic                 clk = 1'b0;
  logic                 reset, pix_en, cfg_valid, cfg_ready, cfg_sel, cfg_pol, irq_clear;
  logic [CW-2:0]        cfg_res, cfg_fp, cfg_sync, cfg_bp;
  logic signed [CW-1:0] irq_line, x, y;
  logic                 hsync, vsync, de, frame_start, irq;
  logic [7:0]           frame_cnt;

  video_timing_gen #(
    .CW(CW), .H_RES(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_RES(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1'b0), .V_POL(1'b0), .FRAME_W(8)
  ) dut (
    .clk(clk), .reset(reset), .pix_en(pix_en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_sel(cfg_sel), .cfg_res(cfg_res), .cfg_fp(cfg_fp), .cfg_sync(cfg_sync), .cfg_bp(cfg_bp),
    .cfg_pol(cfg_pol), .irq_line(irq_line), .irq_clear(irq_clear), .x(x), .y(y),
    .hsync(hsync), .vsync(vsync), .de(de), .frame_start(frame_start), .irq(irq),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ex, ey;
    bit hs, vs, de, fs, irq;
    int fc;
    bit [1:0] pend;
  } exp_t;

  exp_t q[$];
  exp_t last;
  int   n_vec = 0, n_err = 0;
  bit   track = 0, upd = 0;

  // Reference mode state: active, staged, pending; cur = pixel index the counters hold.
  int m_res[2], m_fp[2], m_sy[2], m_bp[2];
  int s_res[2], s_fp[2], s_sy[2], s_bp[2];
  bit m_pol[2], s_pol[2];
  bit [1:0] m_pend;
  int cur, fc_m;
  bit irq_m;

  function automatic bit sync_exp(int c, int ax);
    bit cond;
    cond = (c >= -(m_sy[ax] + m_bp[ax])) && (c < -m_bp[ax]);
    return m_pol[ax] ? cond : !cond;
  endfunction

  function automatic int blank_of(int ax);
    return m_fp[ax] + m_sy[ax] + m_bp[ax];
  endfunction

  function automatic int frame_last();
    return (m_res[0] + blank_of(0)) * (m_res[1] + blank_of(1)) - 1;
  endfunction

  function automatic exp_t disp(int n);
    exp_t e;
    int lp;
    lp     = m_res[0] + blank_of(0);
    e.ex   = n % lp - blank_of(0);
    e.ey   = n / lp - blank_of(1);
    e.hs   = sync_exp(e.ex, 0);
    e.vs   = sync_exp(e.ey, 1);
    e.de   = (e.ex >= 0) && (e.ey >= 0);
    e.fs   = (e.ex == 0) && (e.ey == 0);
    e.irq  = 0;
    e.fc   = 0;
    e.pend = 0;
    return e;
  endfunction

  function automatic exp_t rst_exp();
    exp_t e;
    e.ex = -3; e.ey = -3; e.hs = 1; e.vs = 1; e.de = 0; e.fs = 0;
    e.irq = 0; e.fc = 0; e.pend = 2'b00;
    return e;
  endfunction

  task automatic model_reset();
    for (int a = 0; a < 2; a++) begin
      m_fp[a] = 1; m_sy[a] = 1; m_bp[a] = 1; m_pol[a] = 0;
    end
    m_res[0] = 4; m_res[1] = 2;
    s_res = m_res; s_fp = m_fp; s_sy = m_sy; s_bp = m_bp; s_pol = m_pol;
    m_pend = 2'b00; cur = 0; fc_m = 0; irq_m = 0;
  endtask

  task automatic chk(string nm, int act, int expv);
    n_vec++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
    end
  endtask

  // Drive inputs for the next clock edge and push the response expected after it.
  task automatic step(input bit en, input bit wr = 0, input bit sel = 0, input int r = 0,
                      input int f = 0, input int s = 0, input int b = 0, input bit p = 0,
                      input bit clr = 0);
    exp_t e;
    bit fe, set;
    @(posedge clk); #1;
    pix_en = en; cfg_valid = wr; irq_clear = clr;
    if (wr) begin
      cfg_sel = sel; cfg_res = 11'(r); cfg_fp = 11'(f); cfg_sync = 11'(s); cfg_bp = 11'(b);
      cfg_pol = p;
    end
    if (en) begin
      e   = disp(cur);
      fe  = (cur == frame_last());
      set = (e.ey == int'(irq_line)) && (e.ex == -blank_of(0));
      irq_m = set ? 1'b1 : (clr ? 1'b0 : irq_m);
      if (fe) begin
        fc_m = (fc_m + 1) % 256;
        for (int a = 0; a < 2; a++) begin
          if (m_pend[a]) begin
            m_res[a] = s_res[a]; m_fp[a] = s_fp[a]; m_sy[a] = s_sy[a];
            m_bp[a] = s_bp[a]; m_pol[a] = s_pol[a]; m_pend[a] = 0;
          end
        end
        cur = 0;
      end else begin
        cur++;
      end
      if (wr && !m_pend[sel]) begin
        s_res[sel] = (r == 0) ? 1 : r; s_fp[sel] = f; s_sy[sel] = s; s_bp[sel] = b;
        s_pol[sel] = p; m_pend[sel] = 1;
      end
      e.irq = irq_m; e.fc = fc_m; e.pend = m_pend;
      q.push_back(e);
    end
  endtask

  task automatic run(int n, int clr_a = -1, int clr_b = -1);
    for (int i = 0; i < n; i++) step(1, .clr((cur == clr_a) || (cur == clr_b)));
  endtask

  always @(posedge clk) upd <= pix_en && !reset;

  always @(negedge clk) begin
    if (upd) begin
      if (q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL scoreboard_underflow: got empty queue, expected an entry");
      end else begin
        last = q.pop_front();
      end
    end
    if (reset) last = rst_exp();
    if (track) begin
      n_vec++;
      if (int'(x) != last.ex || int'(y) != last.ey || hsync != last.hs || vsync != last.vs ||
          de != last.de || frame_start != last.fs || irq != last.irq ||
          int'(frame_cnt) != last.fc || cfg_ready != !last.pend[cfg_sel]) begin
        n_err++;
        $display("FAIL outputs@%0t: got x=%0d y=%0d hs=%0b vs=%0b de=%0b fs=%0b irq=%0b fc=%0d rdy=%0b, expected x=%0d y=%0d hs=%0b vs=%0b de=%0b fs=%0b irq=%0b fc=%0d rdy=%0b",
                 $time, x, y, hsync, vsync, de, frame_start, irq, frame_cnt, cfg_ready,
                 last.ex, last.ey, last.hs, last.vs, last.de, last.fs, last.irq, last.fc,
                 !last.pend[cfg_sel]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 0; pix_en = 0; cfg_valid = 0; cfg_sel = 0; cfg_pol = 0; irq_clear = 0;
    cfg_res = '0; cfg_fp = '0; cfg_sync = '0; cfg_bp = '0; irq_line = 12'sd1;
    model_reset();
    #2 reset = 1; track = 1;
    repeat (3) @(posedge clk);
    #1 reset = 0;

    // Frame 1: irq rises at y == 1, x == -3 (pixel index 28).
    run(35);
    step(0);
    chk("frame_cnt_after_35", int'(frame_cnt), 1);
    chk("x_last_pixel", int'(x), 3);
    chk("y_last_pixel", int'(y), 1);
    chk("irq_after_frame1", int'(irq), 1);
    // Frame 2: plain clear at index 5, clear coinciding with a new match at index 28.
    run(35, 5, 28);
    irq_line = 12'sd1000;
    run(35, 3);

    // Half-rate pixel strobe over two frames.
    for (int i = 0; i < 70; i++) begin
      step(1);
      step(0);
    end

    // Mid-frame horizontal reprogram: 8/2/2/2 active-high.
    run(10);
    step(1, 1, 0, 8, 2, 2, 2, 1);
    run(200);

    // Vertical write landing exactly on the frame-end pixel.
    for (int i = 0; i < 200 && cur != frame_last(); i++) step(1);
    step(1, 1, 1, 3, 1, 1, 1, 1);
    run(250);

    // Reset mid-line with a horizontal write still pending.
    run(20);
    step(1, 1, 0, 5, 1, 1, 1, 0);
    run(3);
    @(posedge clk); #1;
    pix_en = 0; cfg_valid = 0; irq_clear = 0; reset = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 0;
    run(40);
    step(0);
    step(0);
    chk("frame_cnt_after_reset", int'(frame_cnt), 1);
    chk("queue_drained", q.size(), 0);
    track = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Two-axis, runtime-reprogrammable video timing generator. It replaces a chained pair of fixed per-axis timing counters with one block that owns both horizontal and vertical counters, registers aligned pixel coordinates, sync and data-enable, and applies new mode settings atomically at frame boundaries. It also provides a frame counter and a sticky line-match interrupt for the pattern/sprite logic downstream.

## Interface
- CW, 12: signed counter width; config fields are CW-1 bits unsigned
- H_RES / H_FP / H_SYNC / H_BP, 640 / 16 / 96 / 48: reset-default horizontal timing (pixels)
- V_RES / V_FP / V_SYNC / V_BP, 480 / 10 / 2 / 33: reset-default vertical timing (lines)
- H_POL / V_POL, 0 / 0: reset-default sync polarity (1 = active-high)
- FRAME_W, 8: frame counter width
- clk  in  1  pixel-domain clock
- reset  in  1  asynchronous, active-high reset
- pix_en  in  1  pixel strobe; counters and output registers advance only when high
- cfg_valid  in  1  config write request
- cfg_ready  out  1  = !pending[cfg_sel]
- cfg_sel  in  1  0 = horizontal axis, 1 = vertical axis
- cfg_res, cfg_fp, cfg_sync, cfg_bp  in  CW-1 each  timing fields for the selected axis
- cfg_pol  in  1  sync polarity for the selected axis
- irq_line  in  CW  signed line number for the line-match interrupt
- irq_clear  in  1  clears irq
- x, y  out  CW signed  current pixel coordinates; active region x,y >= 0
- hsync, vsync  out  1  polarity-applied sync
- de  out  1  high when x >= 0 and y >= 0
- frame_start  out  1  high while x == 0 and y == 0
- irq  out  1  sticky line-match flag
- frame_cnt  out  FRAME_W  completed-frame count, wraps modulo 2^FRAME_W

## Operation
- Per axis, active config {res, fp, sync, bp, pol}; blank B = fp + sync + bp.
- Counters hc, vc: hc runs -B_h .. res_h-1; on pix_en at hc == res_h-1 it reloads -B_h and vc increments; vc runs -B_v .. res_v-1 and reloads -B_v at its last line.
- Frame end = pix_en && hc == res_h-1 && vc == res_v-1.
- Sync condition per axis: -(sync+bp) <= count < -bp; sync out = pol ? cond : ~cond. sync == 0 means sync never asserts.
- Config: accepted when cfg_valid && cfg_ready; the fields go to the staging set for cfg_sel and set pending[cfg_sel]. cfg_res == 0 is stored as 1.
- On frame end, every pending axis copies staging to active and clears pending. Both counters reload with the new blanking values in that same cycle.
- A write accepted in the frame-end cycle is not applied until the next frame end.
- irq sets when outputs first show y == irq_line and x == -B_h of the active config. irq_clear clears it; if set and clear coincide, set wins.
- frame_cnt increments on frame end.
- Width rule: B and res for each axis must be <= 2^(CW-1)-1. Counters are signed CW bits and do not saturate. The bench must not program values outside this range.

## Timing
- Async reset: active config = parameters, staging = parameters, pending = 0, hc = -B_h, vc = -B_v.
- Output reset values: x = -(H_FP+H_SYNC+H_BP), y = -(V_FP+V_SYNC+V_BP), de = 0, frame_start = 0, hsync = ~H_POL, vsync = ~V_POL, irq = 0, frame_cnt = 0.
- Outputs x, y, hsync, vsync, de and frame_start are registered on pix_en from the counter state. They lag the counters by exactly one enabled pixel and are mutually aligned.
- With pix_en = 0, all state and outputs hold.
- Reset asserted mid-frame returns to defaults immediately and discards staged writes.
- cfg_ready drops the clk after acceptance and rises the clk after the applying frame end.

## Test plan
- Tiny mode via reset params (H 4/1/1/1, V 2/1/1/1, polarity 0), pix_en = 1 -> line period 7 clks, frame period 35 clks; hsync low exactly when x == -2; de high for x in 0..3, y in 0..1; frame_cnt = 1 after 35 enabled pixels.
- pix_en toggling every other clk -> identical x/y/sync sequence at half rate; outputs hold on pix_en = 0 cycles.
- Horizontal write (res 8, fp 2, sync 2, bp 2, pol 1) mid-frame -> old timing until frame end; cfg_ready low until then; next frame line period 14 with active-high hsync.
- Write accepted on the exact frame-end cycle -> not applied at that frame end; applied one frame later.
- irq_line = 1 -> irq rises when y == 1 and x == -B_h; irq_clear asserted on the same cycle as a new match -> irq stays 1.
- Reset asserted mid-line after a pending write -> all outputs at reset values, pending cleared, parameter timing resumes.
